// File: rtl/reaction_round_ctrl.sv
// Reaction-time game round controller: blank pause, one-hot button request,
// timed response window, error hold-off and per-game hit/best-time bookkeeping.
module reaction_round_ctrl #(
  parameter  int N_BTN      = 3,
  parameter  int TW         = 16,
  parameter  int BLANK_MS   = 2000,
  parameter  int TIMEOUT_MS = 5000,
  parameter  int HOLD_MS    = 1000,
  parameter  int ROUNDS     = 4,
  localparam int RW         = $clog2(ROUNDS + 1)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iMsTick,
  input  logic             iStart,
  input  logic [N_BTN-1:0] iButtons,
  input  logic [N_BTN-1:0] iButtonReq,
  output logic             oNewButtonReq,
  output logic             oBlank,
  output logic             oShowResult,
  output logic [1:0]       oError,
  output logic [TW-1:0]    oRespTime,
  output logic [TW-1:0]    oBestTime,
  output logic [RW-1:0]    oHits,
  output logic [RW-1:0]    oRound,
  output logic             oDone,
  output logic [2:0]       oState
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BLANK   = 3'd1,
    REQUEST = 3'd2,
    WAIT    = 3'd3,
    RESULT  = 3'd4,
    ERROR   = 3'd5,
    SUMMARY = 3'd6
  } stateT;

  localparam logic [TW-1:0] BLANK_T   = TW'(BLANK_MS);
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_MS);
  localparam logic [TW-1:0] HOLD_T    = TW'(HOLD_MS);
  localparam logic [RW-1:0] ROUNDS_T  = RW'(ROUNDS);

  stateT         state;
  logic [TW-1:0] timer;
  logic [TW-1:0] respTime;
  logic [TW-1:0] bestTime;
  logic [RW-1:0] hits;
  logic [RW-1:0] round;
  logic [RW-1:0] roundNext;
  logic [1:0]    errCode;

  assign roundNext = round + 1'b1;

  // Every transition clears the timer; the later assignment overrides the tick increment.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      timer    <= '0;
      respTime <= '0;
      bestTime <= '1;
      hits     <= '0;
      round    <= '0;
      errCode  <= 2'd0;
    end else begin
      if (iMsTick && (timer != '1)) timer <= timer + 1'b1;
      case (state)
        IDLE, SUMMARY: begin
          if (iStart) begin
            round    <= '0;
            hits     <= '0;
            bestTime <= '1;
            state    <= BLANK;
            timer    <= '0;
          end
        end
        BLANK: begin
          if (iButtons != '0) begin
            errCode <= 2'd3;
            state   <= ERROR;
            timer   <= '0;
          end else if (timer >= BLANK_T) begin
            state <= REQUEST;
            timer <= '0;
          end
        end
        REQUEST: begin
          state <= WAIT;
          timer <= '0;
        end
        // Timeout outranks a correct press; any non-exact press is a wrong button.
        WAIT: begin
          if (timer >= TIMEOUT_T) begin
            errCode <= 2'd2;
            state   <= ERROR;
            timer   <= '0;
          end else if (iButtons == iButtonReq) begin
            respTime <= timer;
            hits     <= hits + 1'b1;
            if (timer < bestTime) bestTime <= timer;
            state    <= RESULT;
            timer    <= '0;
          end else if (iButtons != '0) begin
            errCode <= 2'd1;
            state   <= ERROR;
            timer   <= '0;
          end
        end
        RESULT: begin
          if (iButtons == '0) begin
            round <= roundNext;
            state <= (roundNext == ROUNDS_T) ? SUMMARY : BLANK;
            timer <= '0;
          end
        end
        ERROR: begin
          if ((iButtons == '0) && (timer >= HOLD_T)) begin
            round <= roundNext;
            state <= (roundNext == ROUNDS_T) ? SUMMARY : BLANK;
            timer <= '0;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign oNewButtonReq = (state == REQUEST);
  assign oBlank        = (state == IDLE) || (state == BLANK) || (state == REQUEST);
  assign oShowResult   = (state == RESULT) || (state == ERROR) || (state == SUMMARY);
  assign oError        = (state == ERROR) ? errCode : 2'd0;
  assign oRespTime     = (state == SUMMARY) ? bestTime : respTime;
  assign oBestTime     = bestTime;
  assign oHits         = hits;
  assign oRound        = round;
  assign oDone         = (state == SUMMARY);
  assign oState        = state;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed and randomized game sequences for reaction_round_ctrl, checked against
// expected round outcomes computed from tick counts and game rules.
module tb_reaction_round_ctrl;

  localparam int N_BTN      = 3;
  localparam int TW         = 16;
  localparam int BLANK_MS   = 2000;
  localparam int TIMEOUT_MS = 5000;
  localparam int HOLD_MS    = 1000;
  localparam int ROUNDS     = 4;
  localparam int RW         = $clog2(ROUNDS + 1);
  localparam int NONE_TIME  = (1 << TW) - 1;

  logic             iClk = 1'b0;
  logic             iRst;
  logic             iMsTick;
  logic             iStart;
  logic [N_BTN-1:0] iButtons;
  logic [N_BTN-1:0] iButtonReq;
  logic             oNewButtonReq;
  logic             oBlank;
  logic             oShowResult;
  logic [1:0]       oError;
  logic [TW-1:0]    oRespTime;
  logic [TW-1:0]    oBestTime;
  logic [RW-1:0]    oHits;
  logic [RW-1:0]    oRound;
  logic             oDone;
  logic [2:0]       oState;

  int total = 0;
  int bad = 0;
  int expHits, expRound, expBest, expResp;
  int reqPulses = 0;
  bit startNoise = 0;

  reaction_round_ctrl dut (
    .iClk(iClk), .iRst(iRst), .iMsTick(iMsTick), .iStart(iStart),
    .iButtons(iButtons), .iButtonReq(iButtonReq),
    .oNewButtonReq(oNewButtonReq), .oBlank(oBlank), .oShowResult(oShowResult),
    .oError(oError), .oRespTime(oRespTime), .oBestTime(oBestTime),
    .oHits(oHits), .oRound(oRound), .oDone(oDone), .oState(oState)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic noiseBit();
    return startNoise ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic applyStimulus(input logic tick, input logic [N_BTN-1:0] btn, input logic start);
    iMsTick  = tick;
    iButtons = btn;
    iStart   = start;
    @(posedge iClk);
    #1;
    if (oNewButtonReq) reqPulses++;
  endtask

  task automatic startGame();
    applyStimulus(1'b0, '0, 1'b1);
    expHits  = 0;
    expRound = 0;
    expBest  = NONE_TIME;
    checkOutput("start.state", 32'(oState), 1);
    checkOutput("start.hits", 32'(oHits), 0);
    checkOutput("start.round", 32'(oRound), 0);
    checkOutput("start.best", 32'(oBestTime), NONE_TIME);
    checkOutput("start.resp", 32'(oRespTime), expResp);
  endtask

  // fsOnly=1: press during the blank pause after 'delay' ticks.
  // Otherwise: after the request, wait 'delay' ticks then present 'press'.
  task automatic playRound(input bit fsOnly, input int delay, input logic [N_BTN-1:0] req,
                           input logic [N_BTN-1:0] press, input int relDelay, input bit gappy);
    int cnt, cyc, pulses0, expErr, exitAt;
    logic t;
    iButtonReq = req;
    pulses0 = reqPulses;
    expErr = 0;
    if (fsOnly) begin
      for (int i = 0; i < delay; i++) applyStimulus(1'b1, '0, noiseBit());
      applyStimulus(1'b0, press, noiseBit());
      expErr = 3;
      checkOutput("falseStart.noReqPulse", reqPulses - pulses0, 0);
    end else begin
      cyc = 0;
      while (oState == 3'd1 && cyc < BLANK_MS + 10) begin
        applyStimulus(1'b1, '0, noiseBit());
        cyc++;
      end
      checkOutput("blank.cycles", cyc, BLANK_MS + 1);
      checkOutput("request.pulse", 32'(oNewButtonReq), 1);
      applyStimulus(1'b0, '0, noiseBit());
      checkOutput("wait.state", 32'(oState), 3);
      checkOutput("request.onePulse", reqPulses - pulses0, 1);
      cnt = 0;
      while (cnt < delay) begin
        t = gappy ? logic'($urandom_range(0, 3) != 0) : 1'b1;
        applyStimulus(t, '0, noiseBit());
        cnt += int'(t);
      end
      applyStimulus(1'b0, press, noiseBit());
      if (cnt >= TIMEOUT_MS) expErr = 2;
      else if (press != req) expErr = 1;
    end

    if (expErr == 0) begin
      expHits++;
      expResp = delay;
      if (delay < expBest) expBest = delay;
      checkOutput("result.state", 32'(oState), 4);
      checkOutput("result.error", 32'(oError), 0);
      checkOutput("result.resp", 32'(oRespTime), expResp);
      checkOutput("result.hits", 32'(oHits), expHits);
      checkOutput("result.best", 32'(oBestTime), expBest);
      checkOutput("result.show", 32'(oShowResult), 1);
      for (int i = 0; i < relDelay; i++) applyStimulus(logic'($urandom_range(0, 1)), press, noiseBit());
      checkOutput("result.heldWhilePressed", 32'(oState), 4);
      applyStimulus(1'b0, '0, noiseBit());
    end else begin
      checkOutput("error.state", 32'(oState), 5);
      checkOutput("error.code", 32'(oError), expErr);
      checkOutput("error.hits", 32'(oHits), expHits);
      checkOutput("error.best", 32'(oBestTime), expBest);
      for (int i = 0; i < relDelay; i++) applyStimulus(1'b1, press, noiseBit());
      checkOutput("error.codeHeld", 32'(oError), expErr);
      cyc = 0;
      while (oState == 3'd5 && cyc < HOLD_MS + 10) begin
        applyStimulus(1'b1, '0, noiseBit());
        cyc++;
      end
      exitAt = (relDelay + 1 > HOLD_MS + 1) ? relDelay + 1 : HOLD_MS + 1;
      checkOutput("error.cycles", relDelay + cyc, exitAt);
    end
    expRound++;
    checkOutput("exit.state", 32'(oState), (expRound == ROUNDS) ? 6 : 1);
    checkOutput("exit.round", 32'(oRound), expRound);
    checkOutput("exit.error", 32'(oError), 0);
  endtask

  task automatic checkSummary();
    checkOutput("summary.state", 32'(oState), 6);
    checkOutput("summary.done", 32'(oDone), 1);
    checkOutput("summary.show", 32'(oShowResult), 1);
    checkOutput("summary.hits", 32'(oHits), expHits);
    checkOutput("summary.round", 32'(oRound), ROUNDS);
    checkOutput("summary.respIsBest", 32'(oRespTime), expBest);
    checkOutput("summary.best", 32'(oBestTime), expBest);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".state"}, 32'(oState), 0);
    checkOutput({tag, ".blank"}, 32'(oBlank), 1);
    checkOutput({tag, ".resp"}, 32'(oRespTime), 0);
    checkOutput({tag, ".best"}, 32'(oBestTime), NONE_TIME);
    checkOutput({tag, ".hits"}, 32'(oHits), 0);
    checkOutput({tag, ".round"}, 32'(oRound), 0);
    checkOutput({tag, ".error"}, 32'(oError), 0);
    checkOutput({tag, ".done"}, 32'(oDone), 0);
    checkOutput({tag, ".show"}, 32'(oShowResult), 0);
    checkOutput({tag, ".newReq"}, 32'(oNewButtonReq), 0);
  endtask

  initial begin
    logic [N_BTN-1:0] req, press;
    int delay, cyc;
    iRst = 1'b1;
    iMsTick = 1'b0;
    iStart = 1'b0;
    iButtons = '0;
    iButtonReq = 3'b001;
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    checkReset("reset");
    iRst = 1'b0;
    expResp = 0;

    $display("[TB] game 1: correct, wrong, false start, timeout-with-press");
    startGame();
    playRound(0, 350, 3'b010, 3'b010, 3, 0);
    playRound(0, 10, 3'b100, 3'b001, 190, 0);
    playRound(1, 1500, 3'b001, 3'b001, 0, 0);
    playRound(0, TIMEOUT_MS, 3'b001, 3'b001, 0, 0);
    checkSummary();

    $display("[TB] game 2: 400, 250, timeout, 300 with start noise");
    startGame();
    startNoise = 1;
    playRound(0, 400, 3'b100, 3'b100, 5, 1);
    playRound(0, 250, 3'b001, 3'b001, 0, 1);
    playRound(0, TIMEOUT_MS, 3'b010, 3'b000, 0, 0);
    playRound(0, 300, 3'b010, 3'b010, 2, 1);
    startNoise = 0;
    checkSummary();

    $display("[TB] game 3: randomized rounds");
    startGame();
    startNoise = 1;
    for (int r = 0; r < ROUNDS; r++) begin
      req = 3'b001 << $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) press = req;
      else press = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) begin
        playRound(1, $urandom_range(0, BLANK_MS - 1), req, press, $urandom_range(0, 1200), 0);
      end else begin
        delay = ($urandom_range(0, 6) == 0) ? TIMEOUT_MS : $urandom_range(0, 3000);
        playRound(0, delay, req, press, (press == req) ? $urandom_range(0, 50) : $urandom_range(0, 1200), 1);
      end
    end
    startNoise = 0;
    checkSummary();

    $display("[TB] reset during response window");
    startGame();
    cyc = 0;
    while (oState != 3'd3 && cyc < BLANK_MS + 10) begin
      applyStimulus(1'b1, '0, 1'b0);
      cyc++;
    end
    checkOutput("midRound.inWait", 32'(oState), 3);
    for (int i = 0; i < 37; i++) applyStimulus(1'b1, '0, 1'b0);
    iRst = 1'b1;
    applyStimulus(1'b1, '0, 1'b0);
    checkReset("midReset");
    iRst = 1'b0;
    applyStimulus(1'b1, '0, 1'b0);
    checkOutput("afterReset.idle", 32'(oState), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
